// File: rtl/dfd_cla_debug_signals_match_multi_pkg.sv
// Shared types and defaults for the CLA debug-signal mask/match detector.
package dfd_cla_pkg;
    localparam int CLA_DEBUG_SIGNALS_WIDTH = 64;
    localparam int CLA_MATCH_NUM_CHANNELS  = 4;
    localparam int CLA_MATCH_COUNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        CLA_MATCH_LEVEL    = 2'd0,
        CLA_MATCH_RISE     = 2'd1,
        CLA_MATCH_FALL     = 2'd2,
        CLA_MATCH_ANY_EDGE = 2'd3
    } cla_match_mode_e;
endpackage

// File: rtl/dfd_cla_debug_signals_match_multi_if.sv
// Observed bus, per-channel CSR configuration and per-channel match results.
interface dfd_cla_debug_signals_match_multi_if
    import dfd_cla_pkg::*;
#(
    parameter int DEBUG_SIGNALS_WIDTH = CLA_DEBUG_SIGNALS_WIDTH,
    parameter int NUM_CHANNELS        = CLA_MATCH_NUM_CHANNELS,
    parameter int COUNT_WIDTH         = CLA_MATCH_COUNT_WIDTH
) ();
    logic [DEBUG_SIGNALS_WIDTH-1:0]                   debug_signals;
    logic [NUM_CHANNELS-1:0][DEBUG_SIGNALS_WIDTH-1:0] match_value;
    logic [NUM_CHANNELS-1:0][DEBUG_SIGNALS_WIDTH-1:0] match_mask;
    cla_match_mode_e [NUM_CHANNELS-1:0]               match_mode;
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0]         match_threshold;
    logic [NUM_CHANNELS-1:0]                          channel_enable;
    logic [NUM_CHANNELS-1:0]                          counter_clear;
    logic [NUM_CHANNELS-1:0]                          positive_match;
    logic [NUM_CHANNELS-1:0]                          negative_match;
    logic [NUM_CHANNELS-1:0]                          threshold_hit;
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0]         match_count;

    modport master (
        output debug_signals, match_value, match_mask, match_mode,
               match_threshold, channel_enable, counter_clear,
        input  positive_match, negative_match, threshold_hit, match_count
    );

    modport slave (
        input  debug_signals, match_value, match_mask, match_mode,
               match_threshold, channel_enable, counter_clear,
        output positive_match, negative_match, threshold_hit, match_count
    );
endinterface

// File: rtl/dfd_cla_debug_signals_match_multi_channel.sv
// One match channel: masked compare, edge history, mode select,
// saturating occurrence counter and sticky threshold flag.
module dfd_cla_match_channel
    import dfd_cla_pkg::*;
#(
    parameter int DEBUG_SIGNALS_WIDTH = CLA_DEBUG_SIGNALS_WIDTH,
    parameter int COUNT_WIDTH         = CLA_MATCH_COUNT_WIDTH
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [DEBUG_SIGNALS_WIDTH-1:0] debug_signals,
    input  logic [DEBUG_SIGNALS_WIDTH-1:0] match_value,
    input  logic [DEBUG_SIGNALS_WIDTH-1:0] match_mask,
    input  cla_match_mode_e                match_mode,
    input  logic [COUNT_WIDTH-1:0]         match_threshold,
    input  logic                           channel_enable,
    input  logic                           counter_clear,
    output logic                           positive_match,
    output logic                           negative_match,
    output logic                           threshold_hit,
    output logic [COUNT_WIDTH-1:0]         match_count
);
    logic                   raw;
    logic                   raw_q;
    logic                   event_hit;
    logic                   evt;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   hit_next;

    assign raw = ((debug_signals & match_mask) == (match_value & match_mask));

    always_comb begin
        event_hit = raw;
        unique case (match_mode)
            CLA_MATCH_LEVEL:    event_hit = raw;
            CLA_MATCH_RISE:     event_hit = raw & ~raw_q;
            CLA_MATCH_FALL:     event_hit = ~raw & raw_q;
            CLA_MATCH_ANY_EDGE: event_hit = raw ^ raw_q;
            default:            event_hit = raw;
        endcase
    end

    assign evt = event_hit & channel_enable;

    // Clear beats a coincident event; the counter saturates instead of wrapping.
    always_comb begin
        count_next = match_count;
        hit_next   = threshold_hit;
        if (counter_clear) begin
            count_next = '0;
            hit_next   = 1'b0;
        end else begin
            if (evt && (match_count != '1))
                count_next = match_count + 1'b1;
            if ((match_threshold != '0) && (count_next >= match_threshold))
                hit_next = 1'b1;
        end
    end

    // History tracks the raw compare even while the channel is disabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            raw_q          <= 1'b0;
            positive_match <= 1'b0;
            negative_match <= 1'b1;
            threshold_hit  <= 1'b0;
            match_count    <= '0;
        end else begin
            raw_q          <= raw;
            positive_match <= evt;
            negative_match <= ~evt;
            threshold_hit  <= hit_next;
            match_count    <= count_next;
        end
    end
endmodule

// File: rtl/dfd_cla_debug_signals_match_multi.sv
// Multi-channel mask/match detector on the CLA debug-signal bus; replicates
// one independent match channel per configured channel.
module dfd_cla_debug_signals_match_multi
    import dfd_cla_pkg::*;
#(
    parameter int DEBUG_SIGNALS_WIDTH = CLA_DEBUG_SIGNALS_WIDTH,
    parameter int NUM_CHANNELS        = CLA_MATCH_NUM_CHANNELS,
    parameter int COUNT_WIDTH         = CLA_MATCH_COUNT_WIDTH
) (
    input logic                               clock,
    input logic                               reset_n,
    dfd_cla_debug_signals_match_multi_if.slave bus
);
    logic [NUM_CHANNELS-1:0]                  pos;
    logic [NUM_CHANNELS-1:0]                  neg;
    logic [NUM_CHANNELS-1:0]                  hit;
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] cnt;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        dfd_cla_match_channel #(
            .DEBUG_SIGNALS_WIDTH(DEBUG_SIGNALS_WIDTH),
            .COUNT_WIDTH        (COUNT_WIDTH)
        ) u_ch (
            .clock          (clock),
            .reset_n        (reset_n),
            .debug_signals  (bus.debug_signals),
            .match_value    (bus.match_value[g]),
            .match_mask     (bus.match_mask[g]),
            .match_mode     (bus.match_mode[g]),
            .match_threshold(bus.match_threshold[g]),
            .channel_enable (bus.channel_enable[g]),
            .counter_clear  (bus.counter_clear[g]),
            .positive_match (pos[g]),
            .negative_match (neg[g]),
            .threshold_hit  (hit[g]),
            .match_count    (cnt[g])
        );
    end

    assign bus.positive_match = pos;
    assign bus.negative_match = neg;
    assign bus.threshold_hit  = hit;
    assign bus.match_count    = cnt;
endmodule

// File: tb/tb_dfd_cla_debug_signals_match_multi.sv
// Directed and randomized checks of the multi-channel matcher against a
// cycle-level reference model of the match/count/threshold rules.
module tb_dfd_cla_debug_signals_match_multi;
    import dfd_cla_pkg::*;

    localparam int DW  = 64;
    localparam int NC  = 4;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Reference model state
    int m_cnt [NC];
    bit m_prev[NC];
    bit m_hit [NC];
    bit m_pos [NC];

    dfd_cla_debug_signals_match_multi_if #(
        .DEBUG_SIGNALS_WIDTH(DW), .NUM_CHANNELS(NC), .COUNT_WIDTH(CW)
    ) bus ();

    dfd_cla_debug_signals_match_multi #(
        .DEBUG_SIGNALS_WIDTH(DW), .NUM_CHANNELS(NC), .COUNT_WIDTH(CW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = 0; m_prev[c] = 0; m_hit[c] = 0; m_pos[c] = 0;
        end
    endtask

    // Advance one clock: predict from current inputs, then compare every channel.
    task automatic step();
        for (int c = 0; c < NC; c++) begin
            bit raw, ev;
            raw = ((bus.debug_signals & bus.match_mask[c]) == (bus.match_value[c] & bus.match_mask[c]));
            case (int'(bus.match_mode[c]))
                0:       ev = raw;
                1:       ev = raw && !m_prev[c];
                2:       ev = !raw && m_prev[c];
                default: ev = raw != m_prev[c];
            endcase
            ev = ev && bus.channel_enable[c];
            if (bus.counter_clear[c]) m_cnt[c] = 0;
            else if (ev && m_cnt[c] < MAX) m_cnt[c] = m_cnt[c] + 1;
            if (bus.counter_clear[c]) m_hit[c] = 0;
            else if (int'(bus.match_threshold[c]) != 0 && m_cnt[c] >= int'(bus.match_threshold[c])) m_hit[c] = 1;
            m_pos[c]  = ev;
            m_prev[c] = raw;
        end
        @(posedge clock);
        #1;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("ch%0d positive", c), 64'(bus.positive_match[c]), 64'(m_pos[c]));
            chk($sformatf("ch%0d negative", c), 64'(bus.negative_match[c]), 64'(!m_pos[c]));
            chk($sformatf("ch%0d hit", c),      64'(bus.threshold_hit[c]),  64'(m_hit[c]));
            chk($sformatf("ch%0d count", c),    64'(bus.match_count[c]),    64'(m_cnt[c]));
        end
    endtask

    initial begin
        bus.debug_signals   = '0;
        bus.match_value     = '0;
        bus.match_mask      = '0;
        bus.match_mode      = {NC{CLA_MATCH_LEVEL}};
        bus.match_threshold = '0;
        bus.channel_enable  = '0;
        bus.counter_clear   = '0;
        model_reset();

        // Reset state
        #23;
        chk("reset positive", 64'(bus.positive_match), 64'h0);
        chk("reset negative", 64'(bus.negative_match), 64'hF);
        chk("reset hit",      64'(bus.threshold_hit),  64'h0);
        chk("reset count",    64'(bus.match_count),    64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // LEVEL on channel 0
        bus.match_mask[0]     = 64'h00FF;
        bus.match_value[0]    = 64'h00A5;
        bus.channel_enable[0] = 1'b1;
        bus.debug_signals     = 64'hFFA5;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("level pulse", 64'(bus.positive_match[0]), 64'h1);
        end
        bus.debug_signals = 64'hFF00;
        step();
        chk("level drop",  64'(bus.positive_match[0]), 64'h0);
        chk("level count", 64'(bus.match_count[0]),    64'd3);

        // RISE / FALL / ANY_EDGE on channels 1..3
        bus.channel_enable = 4'b1110;
        bus.counter_clear  = 4'b1110;
        for (int c = 1; c < 4; c++) begin
            bus.match_mask[c]  = 64'h00FF;
            bus.match_value[c] = 64'h003C;
        end
        bus.match_mode[1] = CLA_MATCH_RISE;
        bus.match_mode[2] = CLA_MATCH_FALL;
        bus.match_mode[3] = CLA_MATCH_ANY_EDGE;
        step();
        bus.counter_clear = '0;
        for (int i = 0; i < 8; i++) begin
            bus.debug_signals = ((i % 4) < 2) ? 64'hFF3C : 64'hFF00;
            step();
        end
        chk("rise count", 64'(bus.match_count[1]), 64'd2);
        chk("fall count", 64'(bus.match_count[2]), 64'd2);
        chk("any count",  64'(bus.match_count[3]), 64'd4);

        // Threshold, clear-while-matching, saturation on channel 0
        bus.channel_enable[0]  = 1'b1;
        bus.counter_clear      = 4'b0001;
        bus.match_threshold[0] = 4'd5;
        step();
        bus.counter_clear = '0;
        bus.debug_signals = 64'hFFA5;
        for (int i = 0; i < 4; i++) step();
        chk("thr below", 64'(bus.threshold_hit[0]), 64'h0);
        step();
        chk("thr set",   64'(bus.threshold_hit[0]), 64'h1);
        chk("thr count", 64'(bus.match_count[0]),   64'd5);
        bus.counter_clear = 4'b0001;
        step();
        chk("clear count", 64'(bus.match_count[0]),    64'd0);
        chk("clear hit",   64'(bus.threshold_hit[0]),  64'h0);
        chk("clear pulse", 64'(bus.positive_match[0]), 64'h1);
        bus.counter_clear = '0;
        for (int i = 0; i < 20; i++) step();
        chk("saturate", 64'(bus.match_count[0]), 64'(MAX));

        // Enable gating, then enable mid-match in RISE mode
        bus.channel_enable = '0;
        bus.counter_clear  = '1;
        step();
        bus.counter_clear = '0;
        bus.debug_signals = 64'hFF3C;
        for (int i = 0; i < 3; i++) step();
        chk("gated positive", 64'(bus.positive_match[1]), 64'h0);
        chk("gated negative", 64'(bus.negative_match[1]), 64'h1);
        chk("gated count",    64'(bus.match_count[1]),    64'h0);
        bus.channel_enable[1] = 1'b1;
        step();
        chk("late enable rise", 64'(bus.positive_match[1]), 64'h0);

        // Randomized configuration and traffic
        for (int blk = 0; blk < 8; blk++) begin
            for (int c = 0; c < NC; c++) begin
                case ($urandom_range(0, 2))
                    0:       bus.match_mask[c] = 64'h3;
                    1:       bus.match_mask[c] = 64'h0;
                    default: bus.match_mask[c] = 64'h0101;
                endcase
                bus.match_value[c]     = {$urandom, $urandom};
                bus.match_mode[c]      = cla_match_mode_e'($urandom_range(0, 3));
                bus.match_threshold[c] = CW'($urandom_range(0, MAX));
            end
            bus.channel_enable = NC'($urandom);
            for (int i = 0; i < 30; i++) begin
                bus.debug_signals = {$urandom, $urandom};
                for (int c = 0; c < NC; c++) bus.counter_clear[c] = ($urandom_range(0, 7) == 0);
                step();
            end
        end

        // Asynchronous reset mid-operation
        #2;
        reset_n = 1'b0;
        #1;
        chk("async positive", 64'(bus.positive_match), 64'h0);
        chk("async negative", 64'(bus.negative_match), 64'hF);
        chk("async hit",      64'(bus.threshold_hit),  64'h0);
        chk("async count",    64'(bus.match_count),    64'h0);
        model_reset();
        bus.counter_clear = '0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.debug_signals = {$urandom, $urandom};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dfd_cla_debug_signals_match_multi.md
# dfd_cla_debug_signals_match_multi

Multi-channel mask/match detector on the CLA debug-signal bus. It is the parametrised successor of the single-channel matcher. Each channel has its own mask, match value and detection mode (level, rising, falling or any edge), plus a saturating occurrence counter and a sticky threshold flag. It feeds per-channel registered match pulses and counts into the CLA trigger/event logic.

## Interface
Parameters:
- DEBUG_SIGNALS_WIDTH, default from dfd_cla_pkg (64); width of the observed bus.
- NUM_CHANNELS, default 4; number of independent match channels, ≥1.
- COUNT_WIDTH, default 16; occurrence counter width, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  block clock.
- reset_n  in  1  asynchronous active-low reset; assert async, deassert synchronously upstream.
- debug_signals  in  DEBUG_SIGNALS_WIDTH  observed bus.
- match_value  in  [NUM_CHANNELS][DEBUG_SIGNALS_WIDTH]  per-channel compare value.
- match_mask  in  [NUM_CHANNELS][DEBUG_SIGNALS_WIDTH]  per-channel mask; 1 = bit compared.
- match_mode  in  [NUM_CHANNELS] cla_match_mode_e (2 bits)  LEVEL=0, RISE=1, FALL=2, ANY_EDGE=3.
- match_threshold  in  [NUM_CHANNELS][COUNT_WIDTH]  count at which threshold_hit sets; 0 disables.
- channel_enable  in  NUM_CHANNELS  per-channel enable.
- counter_clear  in  NUM_CHANNELS  single-cycle pulse; clears count and sticky flag.
- positive_match  out  NUM_CHANNELS  registered event output.
- negative_match  out  NUM_CHANNELS  registered complement of positive_match.
- threshold_hit  out  NUM_CHANNELS  sticky flag.
- match_count  out  [NUM_CHANNELS][COUNT_WIDTH]  occurrence counter.

## Operation
- Raw compare per channel c: raw[c] = ((debug_signals & mask[c]) == (value[c] & mask[c])). Value bits outside the mask are ignored.
  - An all-zero mask makes raw[c] = 1 constantly.
- History register raw_q[c] <= raw[c] every cycle, regardless of enable. Its reset value is 0.
- Event by mode:
  - LEVEL: raw.
  - RISE: raw & ~raw_q.
  - FALL: ~raw & raw_q.
  - ANY_EDGE: raw ^ raw_q.
- evt[c] = event & channel_enable[c].
- Outputs:
  - positive_match[c] <= evt[c].
  - negative_match[c] <= ~evt[c].
  - A disabled channel therefore gives positive 0, negative 1.
- Counter:
  - If counter_clear[c], count <= 0.
  - Else if evt[c] and count is not all-ones, count <= count+1.
  - The count saturates at 2^COUNT_WIDTH−1 and never wraps.
- Threshold:
  - If counter_clear[c], threshold_hit <= 0.
  - Else if threshold ≠ 0 and count_next ≥ threshold, threshold_hit <= 1.
  - Once set, the flag stays set until clear or reset, even if the threshold is raised later.
- Simultaneous clear and event: clear wins. The count becomes 0, the event is not counted, and positive_match still pulses.
- A mode, mask or value change takes effect on the next compare. It does not clear the count or the history.
- Channels are fully independent; there is no cross-channel logic.

## Timing
- Reset values:
  - positive_match = 0.
  - negative_match = 1.
  - threshold_hit = 0.
  - match_count = 0.
  - raw_q = 0.
- Latency from debug_signals to positive_match, match_count and threshold_hit is 1 cycle, for every mode.
- Edge detection compares against the previous cycle's raw compare.
- First cycle after reset release: raw_q is 0, so a present match in RISE or ANY_EDGE mode registers as an edge. This is intended.
- Reset asserted mid-operation clears all state immediately, asynchronously. No partial counts survive.
- All inputs are synchronous to clock. The configuration inputs are quasi-static CSR outputs but are sampled every cycle.

## Structure
- dfd_cla_pkg adds:
  - typedef enum logic [1:0] cla_match_mode_e {CLA_MATCH_LEVEL, CLA_MATCH_RISE, CLA_MATCH_FALL, CLA_MATCH_ANY_EDGE}.
  - CLA_MATCH_NUM_CHANNELS (default 4).
  - CLA_MATCH_COUNT_WIDTH (default 16).
- One sub-module, dfd_cla_match_channel, holds raw compare, history, mode select, counter and sticky flag for one channel.
  - The top instantiates it NUM_CHANNELS times in a generate loop and only packs and unpacks the ports.

## Test plan
- Reset check: NUM_CHANNELS=4, hold reset_n low, then release with no stimulus. Expect positive 0, negative all-ones, counts 0, threshold_hit 0.
- LEVEL: mask 0x00FF, value 0x0A5. Drive bus 0xFFA5 for 3 cycles, then 0xFF00. Expect positive high for 3 cycles starting 1 cycle after the bus change, count=3, negative the complement.
- RISE/FALL/ANY_EDGE: on channels 1–3, toggle the matching pattern on 2 cycles and off 2 cycles for 8 cycles. Expect counts 2, 2 and 4, with single-cycle pulses aligned 1 cycle after each transition.
- Threshold and clear: threshold 5, LEVEL match held. Expect threshold_hit to set on the cycle count reaches 5. Pulse counter_clear while matching; expect count 0 (not 1), threshold_hit 0, and positive still 1.
- Saturation: COUNT_WIDTH=4, LEVEL match held for 20 cycles. Expect count to stop at 15.
- Enable gating: channel_enable=0 with a matching bus. Expect positive 0, negative 1, count 0. Enable mid-match in RISE mode; expect no event, because history was already 1.
